// File: rtl/vga_scanout_if.sv
// vga_scanout_if: pixel RAM read port between the raster scanout and the frame memory
interface vga_scanout_if;
    logic        rd_en;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic [14:0] rgb_in;
    modport master (output rd_en, x_out, y_out, input rgb_in);
    modport slave  (input rd_en, x_out, y_out, output rgb_in);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing, per-pixel RAM reads and 2-clk aligned RGB555 video out
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    vga_scanout_if.master ram,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [4:0]    r,
    output logic [4:0]    g,
    output logic [4:0]    b,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [9:0]  h_q, v_q, h_d, v_d;
    logic [15:0] frame_cnt_q;
    logic [3:0]  s1_q;
    logic [2:0]  s2_q;
    logic [14:0] rgb_q;
    logic        h_wrap, v_wrap, live, active, hs0, vs0, rd;

    // Timing flags are suppressed in IDLE so an unstarted raster shows no video or sync
    always_comb begin
        h_wrap = h_q == H_LAST;
        v_wrap = v_q == V_LAST;
        h_d    = !en ? h_q : h_wrap ? '0 : h_q + 10'd1;
        v_d    = !(en && h_wrap) ? v_q : v_wrap ? '0 : v_q + 10'd1;
        live   = state_q == RUN || en;
        active = h_q < HA && v_q < VA;
        hs0    = live && h_q >= HS_B && h_q < HS_E;
        vs0    = live && v_q >= VS_B && v_q < VS_E;
        rd     = rst && en && live && active;
    end

    assign ram.rd_en   = rd;
    assign ram.x_out   = h_q;
    assign ram.y_out   = v_q;
    assign frame_start = rd && h_q == '0 && v_q == '0;
    assign frame_cnt   = frame_cnt_q;
    assign hsync       = ~s2_q[2];
    assign vsync       = ~s2_q[1];
    assign de          = s2_q[0];
    assign {r, g, b}   = de ? rgb_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            frame_cnt_q <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            rgb_q       <= '0;
        end else begin
            if (en) state_q <= RUN;
            h_q  <= h_d;
            v_q  <= v_d;
            if (en && h_wrap && v_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
            s1_q <= {hs0, vs0, live && active, rd};
            s2_q <= s1_q[3:1];
            if (s1_q[0]) rgb_q <= ram.rgb_in;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: reduced-geometry raster checked every cycle against a pixel-index model plus literal pins
module tb_vga_scanout;
    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {logic hs; logic vs; logic de; logic rd; int pix;} ent_t;

    logic        clk = 0, rst, en;
    logic        hsync, vsync, de, frame_start;
    logic [4:0]  r, g, b;
    logic [15:0] frame_cnt;

    vga_scanout_if ram();

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ram(ram),
        .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    int          p = 0, frames = 0;
    logic        run = 0, erd;
    ent_t        q1 = '0, q2 = '0, cur;
    logic [14:0] held = '0, nxt_rgb = 15'h7FFF;
    bit          chk_on = 0;

    function automatic logic [14:0] pix_rgb(int n);
        return n == 0 ? 15'h7C0A : 15'(n * 37 + 5);
    endfunction

    function automatic logic act(int n);
        return (n % HT) < HA && (n / HT) < VA;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 ram.rgb_in = nxt_rgb;
    endtask

    // Model: the raster is just a pixel index advanced by each en cycle; outputs show index history 2 clk back
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p = 0; frames = 0; run = 0; q1 = '0; q2 = '0; held = '0; nxt_rgb = 15'h7FFF;
        end else begin
            cur.hs  = (run || en) && (p % HT) >= HA + HF && (p % HT) < HA + HF + HS;
            cur.vs  = (run || en) && (p / HT) >= VA + VF && (p / HT) < VA + VF + VS;
            cur.de  = (run || en) && act(p);
            cur.rd  = en && act(p);
            cur.pix = p;
            q2 = q1;
            q1 = cur;
            if (q2.rd) held = pix_rgb(q2.pix);
            nxt_rgb = cur.rd ? pix_rgb(p) : 15'h7FFF;
            if (en) begin
                run = 1;
                p = (p + 1) % FR;
                if (p == 0) frames++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            erd = rst && en && act(p);
            chk("x_out", 32'(ram.x_out), 32'(p % HT));
            chk("y_out", 32'(ram.y_out), 32'(p / HT));
            chk("rd_en", 32'(ram.rd_en), 32'(erd));
            chk("frame_start", 32'(frame_start), 32'(erd && p == 0));
            chk("frame_cnt", 32'(frame_cnt), 32'(frames % 65536));
            chk("hsync", 32'(hsync), 32'(!q2.hs));
            chk("vsync", 32'(vsync), 32'(!q2.vs));
            chk("de", 32'(de), 32'(q2.de));
            chk("rgb", 32'({r, g, b}), 32'(q2.de ? held : 15'h0));
        end
    end

    initial begin
        int line_rd[VT];
        int de_n, fs_n;
        line_rd = '{default: 0};
        de_n = 0;
        fs_n = 0;
        rst = 0;
        en = 0;
        ram.rgb_in = 15'h7FFF;
        repeat (3) @(posedge clk);
        #1 chk_on = 1;
        @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        repeat (3) tick();
        for (int k = 0; k < 2 * FR + 4; k++) begin
            en = 1;
            @(negedge clk);
            if (k == 0) begin
                chk("first_rd", 32'(ram.rd_en), 32'd1);
                chk("first_fs", 32'(frame_start), 32'd1);
            end
            if (k == 2) begin
                chk("px00_de", 32'(de), 32'd1);
                chk("px00_rgb", 32'({r, g, b}), 32'h7C0A);
            end
            if (k == 24) chk("hs_pre", 32'(hsync), 32'd1);
            if (k == 25) chk("hs_first", 32'(hsync), 32'd0);
            if (k == 29) chk("hs_last", 32'(hsync), 32'd0);
            if (k == 30) chk("hs_post", 32'(hsync), 32'd1);
            if (k == 257) chk("vs_pre", 32'(vsync), 32'd1);
            if (k == 258) chk("vs_first", 32'(vsync), 32'd0);
            if (k == 321) chk("vs_last", 32'(vsync), 32'd0);
            if (k == 322) chk("vs_post", 32'(vsync), 32'd1);
            if (k == FR) chk("fc_one", 32'(frame_cnt), 32'd1);
            if (k == 2 * FR) chk("fc_two", 32'(frame_cnt), 32'd2);
            if (k < FR && ram.rd_en && ram.y_out < 10'(VT)) line_rd[ram.y_out]++;
            if (k >= 2 && k < FR + 2 && de) de_n++;
            if (frame_start) fs_n++;
            tick();
        end
        for (int v = 0; v < VT; v++) chk($sformatf("line_rd[%0d]", v), 32'(line_rd[v]), v < VA ? 32'd20 : 32'd0);
        chk("de_per_frame", 32'(de_n), 32'd120);
        chk("fs_count", 32'(fs_n), 32'd3);
        for (int k = 0; k < 102; k++) begin
            en = 1;
            tick();
        end
        @(negedge clk);
        chk("mid_x", 32'(ram.x_out), 32'd10);
        chk("mid_y", 32'(ram.y_out), 32'd3);
        chk("mid_de", 32'(de), 32'd1);
        @(posedge clk);
        #1 rst = 0;
        #1;
        chk("arst_rd", 32'(ram.rd_en), 32'd0);
        chk("arst_de", 32'(de), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd1);
        chk("arst_rgb", 32'({r, g, b}), 32'd0);
        chk("arst_x", 32'(ram.x_out), 32'd0);
        chk("arst_fc", 32'(frame_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        ram.rgb_in = nxt_rgb;
        fs_n = 0;
        for (int j = 0; j < 2 * FR + 4; j++) begin
            en = (j % 2 == 0);
            @(negedge clk);
            if (j == 0) begin
                chk("rs_x", 32'(ram.x_out), 32'd0);
                chk("rs_rd", 32'(ram.rd_en), 32'd1);
                chk("rs_fc", 32'(frame_cnt), 32'd0);
            end
            if (j == 1) chk("half_no_rd", 32'(ram.rd_en), 32'd0);
            if (j == 2 || j == 3) chk("half_px0", 32'({r, g, b}), 32'h7C0A);
            if (j == 4) chk("half_px1", 32'({r, g, b}), 32'd42);
            if (j == 2 * FR - 2) chk("half_fc0", 32'(frame_cnt), 32'd0);
            if (j == 2 * FR - 1) chk("half_fc1", 32'(frame_cnt), 32'd1);
            if (frame_start) fs_n++;
            tick();
        end
        chk("half_fs_count", 32'(fs_n), 32'd2);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
